player_bullet: RTL and testbench
================================

// Module: player_bullet
// PURPOSE
//  Player laser: consumes the ship's X position and a fire button, spawns one bullet
//  above the ship, advances it upward once per frame, and renders it for the VGA mixer.
//  Sits between ship (position source) and collision logic (hit sink); one bullet in flight max.
// PARAMETERS
//  BULLET_W         2     bullet width in pixels (unscaled)
//  BULLET_H         6     bullet height in pixels
//  SPEED            6     upward pixels per frame
//  SHIP_Y           440   ship top row; spawn row = SHIP_Y - BULLET_H
//  COOLDOWN_FRAMES  8     frames in COOLDOWN after bullet ends (0 treated as 1)
// PORTS
//  clk            in   1   pixel clock; only clock
//  rst_n          in   1   reset, asynchronous, active-low
//  frame_tick     in   1   1-cycle pulse once per frame (start of vblank)
//  fire           in   1   fire button level, already synchronised to clk
//  ship_x_pos     in   10  ship left edge X
//  scale          in   4   ship scale factor (1,2,4..)
//  pix_x, pix_y   in   10  current beam position
//  hit            in   1   1-cycle pulse from collision logic: bullet struck something
//  bullet_on      out  1   pixel belongs to bullet (combinational)
//  bullet_active  out  1   state == FLYING
//  bullet_x       out  10  bullet left edge X
//  bullet_y       out  10  bullet top row Y
//  shot_fired     out  1   1-cycle pulse on spawn (for sound/score)
// BEHAVIOUR
//  Reset (async): state=IDLE, bullet_x=0, bullet_y=0, cd_cnt=0, fire_prev=1, shot_fired=0;
//   bullet_on/bullet_active drop to 0 immediately. fire_prev=1 blocks a shot from a held button.
//  fire sampled only on frame_tick; fire_edge = fire & ~fire_prev; fire_prev <= fire every tick.
//  States IDLE -> FLYING -> COOLDOWN -> IDLE; all moves on clk edge:
//   IDLE: on frame_tick & fire_edge -> FLYING; bullet_x <= spawn_x; bullet_y <= SHIP_Y-BULLET_H;
//     shot_fired=1 for that one cycle. hit ignored.
//   FLYING: hit (any cycle) -> COOLDOWN, load cd_cnt; hit beats frame_tick in same cycle.
//     else on frame_tick: if bullet_y < SPEED -> COOLDOWN (left top), load cd_cnt;
//     else bullet_y <= bullet_y - SPEED. fire ignored (edge tracking still runs).
//   COOLDOWN: on frame_tick: if cd_cnt <= 1 -> IDLE else cd_cnt--. Exactly
//     max(COOLDOWN_FRAMES,1) ticks spent in COOLDOWN. hit ignored.
//  spawn_x: 11-bit sum ship_x_pos + 6*scale (ship centre column); if > 640-BULLET_W
//   clamp to 640-BULLET_W. Never wraps.
//  bullet_on = FLYING & bullet_x <= pix_x < bullet_x+BULLET_W & bullet_y <= pix_y <
//   bullet_y+BULLET_H; bounds compared at 11 bits (no overflow). Registers update 1 cycle
//   after the causing edge; bullet_on follows same cycle combinationally.
//  A fire edge arriving during FLYING/COOLDOWN is lost; button must be re-pressed.
//  rst_n low mid-flight: bullet vanishes, returns IDLE; held fire after release needs new edge.
// TESTING
//  1 Reset with fire=1 held, 3 ticks -> no shot_fired, state IDLE; release, press -> shot on press tick.
//  2 ship_x_pos=312, scale=1, fire edge -> shot_fired 1 cycle, bullet_x=318, bullet_y=434;
//    next tick bullet_y=428; pix(318,434) bullet_on=1 before move, pix(320,434)=0.
//  3 No hit: 72 ticks after spawn bullet_y=2; 73rd tick -> COOLDOWN, bullet_on=0;
//    fire edge during next 7 ticks ignored; after 8th tick IDLE, next edge fires.
//  4 hit pulse mid-frame while FLYING (same cycle as frame_tick) -> COOLDOWN, bullet_y unchanged,
//    bullet_on=0 next cycle; hit in IDLE -> no effect.
//  5 ship_x_pos=630, scale=2, fire -> bullet_x=638 (clamped); scale=4, x=0 -> bullet_x=24.
//  6 rst_n pulsed low mid-flight -> bullet_active/bullet_on 0 asynchronously, outputs at reset values.

Source files
------------

// File: rtl/player_bullet.sv
// rtl/player_bullet.sv - player laser: spawns one bullet above the ship, moves it up each frame, renders it
module player_bullet #(
  parameter int BULLET_W        = 2,
  parameter int BULLET_H        = 6,
  parameter int SPEED           = 6,
  parameter int SHIP_Y          = 440,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [9:0] ship_x_pos,
  input  logic [3:0] scale,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       hit,
  output logic       bullet_on,
  output logic       bullet_active,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic       shot_fired
);

  localparam int CD_FRAMES = (COOLDOWN_FRAMES < 1) ? 1 : COOLDOWN_FRAMES;
  localparam int CD_W      = $clog2(CD_FRAMES + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLYING   = 2'd1;
  localparam logic [1:0] S_COOLDOWN = 2'd2;

  localparam logic [9:0]      SPAWN_Y = 10'(SHIP_Y - BULLET_H);
  localparam logic [9:0]      SPEED_V = 10'(SPEED);
  localparam logic [10:0]     MAX_X   = 11'(640 - BULLET_W);
  localparam logic [10:0]     W_V     = 11'(BULLET_W);
  localparam logic [10:0]     H_V     = 11'(BULLET_H);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(CD_FRAMES);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

  logic [1:0]      state;
  logic [CD_W-1:0] cd_cnt;
  logic            fire_prev;
  logic            fire_edge;
  logic [10:0]     spawn_sum;
  logic [9:0]      spawn_x;

  // Ship centre column, clamped so the bullet never straddles the right edge.
  assign spawn_sum = {1'b0, ship_x_pos} + (11'(scale) * 11'd6);
  assign spawn_x   = (spawn_sum > MAX_X) ? MAX_X[9:0] : spawn_sum[9:0];
  assign fire_edge = fire & ~fire_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      bullet_x   <= '0;
      bullet_y   <= '0;
      cd_cnt     <= '0;
      fire_prev  <= 1'b1;
      shot_fired <= 1'b0;
    end else begin
      shot_fired <= 1'b0;
      if (frame_tick) fire_prev <= fire;
      case (state)
        S_IDLE: begin
          if (frame_tick && fire_edge) begin
            state      <= S_FLYING;
            bullet_x   <= spawn_x;
            bullet_y   <= SPAWN_Y;
            shot_fired <= 1'b1;
          end
        end
        S_FLYING: begin
          // A hit takes priority over the frame move in the same cycle.
          if (hit) begin
            state  <= S_COOLDOWN;
            cd_cnt <= CD_LOAD;
          end else if (frame_tick) begin
            if (bullet_y < SPEED_V) begin
              state  <= S_COOLDOWN;
              cd_cnt <= CD_LOAD;
            end else begin
              bullet_y <= bullet_y - SPEED_V;
            end
          end
        end
        S_COOLDOWN: begin
          if (frame_tick) begin
            if (cd_cnt <= CD_ONE) state <= S_IDLE;
            else                  cd_cnt <= cd_cnt - CD_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bullet_active = (state == S_FLYING);

  always_comb begin
    bullet_on = 1'b0;
    if (bullet_active &&
        ({1'b0, pix_x} >= {1'b0, bullet_x}) && ({1'b0, pix_x} < ({1'b0, bullet_x} + W_V)) &&
        ({1'b0, pix_y} >= {1'b0, bullet_y}) && ({1'b0, pix_y} < ({1'b0, bullet_y} + H_V)))
      bullet_on = 1'b1;
  end

endmodule

// File: tb/tb_player_bullet.sv
// tb/tb_player_bullet.sv - self-checking bench for player_bullet with a frame-level reference model
module tb_player_bullet;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       fire = 1'b0;
  logic [9:0] ship_x_pos = 10'd312;
  logic [3:0] scale = 4'd1;
  logic [9:0] pix_x = 10'd0;
  logic [9:0] pix_y = 10'd0;
  logic       hit = 1'b0;
  logic       bullet_on;
  logic       bullet_active;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;
  logic       shot_fired;

  int checks = 0;
  int errors = 0;

  player_bullet dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .fire(fire),
    .ship_x_pos(ship_x_pos), .scale(scale), .pix_x(pix_x), .pix_y(pix_y), .hit(hit),
    .bullet_on(bullet_on), .bullet_active(bullet_active), .bullet_x(bullet_x),
    .bullet_y(bullet_y), .shot_fired(shot_fired)
  );

  always #5 clk = ~clk;

  // Reference model: a bullet is either flying, or cooling down for a number of
  // remaining frames, or ready; positions kept as plain integers.
  bit m_fly = 0;
  int m_cool = 0;
  int m_x = 0;
  int m_y = 0;
  bit m_prev = 1;
  bit m_shot = 0;

  always @(posedge clk or negedge rst_n) begin : model
    int sx;
    if (!rst_n) begin
      m_fly = 0; m_cool = 0; m_x = 0; m_y = 0; m_prev = 1; m_shot = 0;
    end else begin
      m_shot = 0;
      if (m_fly) begin
        if (hit) begin
          m_fly = 0; m_cool = 8;
        end else if (frame_tick) begin
          if (m_y - 6 < 0) begin m_fly = 0; m_cool = 8; end
          else m_y = m_y - 6;
        end
      end else if (m_cool > 0) begin
        if (frame_tick) m_cool = m_cool - 1;
      end else if (frame_tick && fire && !m_prev) begin
        sx = int'(ship_x_pos) + 6 * int'(scale);
        m_x = (sx > 638) ? 638 : sx;
        m_y = 434;
        m_fly = 1;
        m_shot = 1;
      end
      if (frame_tick) m_prev = fire;
    end
  end

  task automatic do_reset(input bit f);
    rst_n = 1'b0;
    fire = f;
    frame_tick = 1'b0;
    hit = 1'b0;
    #7;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cyc(input bit t, input bit f, input bit h);
    @(negedge clk);
    frame_tick = t;
    fire = f;
    hit = h;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    hit = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    #1;
    checks++; if (bullet_active !== 1'b0 || shot_fired !== 1'b0 || bullet_x !== 10'd0 || bullet_y !== 10'd0) begin
      errors++; $display("FAIL reset_state: active=%b shot=%b x=%0d y=%0d expected 0 0 0 0", bullet_active, shot_fired, bullet_x, bullet_y);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if (shot_fired !== 1'b0 || bullet_active !== 1'b0) begin
        errors++; $display("FAIL held_fire_tick%0d: shot=%b active=%b expected 0 0", i, shot_fired, bullet_active);
      end
    end
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if (shot_fired !== 1'b1 || bullet_active !== 1'b1) begin
      errors++; $display("FAIL press_after_release: shot=%b active=%b expected 1 1", shot_fired, bullet_active);
    end
  endtask

  task automatic test_spawn;
    do_reset(1'b0);
    ship_x_pos = 10'd312; scale = 4'd1;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if (shot_fired !== 1'b1 || bullet_x !== 10'd318 || bullet_y !== 10'd434) begin
      errors++; $display("FAIL spawn: shot=%b x=%0d y=%0d expected 1 318 434", shot_fired, bullet_x, bullet_y);
    end
    pix_x = 10'd318; pix_y = 10'd434; #1;
    checks++; if (bullet_on !== 1'b1) begin errors++; $display("FAIL on_318_434: got %b expected 1", bullet_on); end
    pix_x = 10'd320; #1;
    checks++; if (bullet_on !== 1'b0) begin errors++; $display("FAIL on_320_434: got %b expected 0", bullet_on); end
    pix_x = 10'd319; pix_y = 10'd439; #1;
    checks++; if (bullet_on !== 1'b1) begin errors++; $display("FAIL on_319_439: got %b expected 1", bullet_on); end
    pix_y = 10'd440; #1;
    checks++; if (bullet_on !== 1'b0) begin errors++; $display("FAIL on_319_440: got %b expected 0", bullet_on); end
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if (shot_fired !== 1'b0) begin errors++; $display("FAIL shot_pulse_width: got %b expected 0", shot_fired); end
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if (bullet_y !== 10'd428) begin errors++; $display("FAIL first_move: y=%0d expected 428", bullet_y); end
  endtask

  task automatic test_top_exit;
    do_reset(1'b0);
    ship_x_pos = 10'd312; scale = 4'd1;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 72; i++) cyc(1'b1, 1'b1, 1'b0);
    checks++; if (bullet_y !== 10'd2 || bullet_active !== 1'b1) begin
      errors++; $display("FAIL after_72: y=%0d active=%b expected 2 1", bullet_y, bullet_active);
    end
    cyc(1'b1, 1'b1, 1'b0);
    pix_x = 10'd318; pix_y = 10'd2; #1;
    checks++; if (bullet_active !== 1'b0 || bullet_on !== 1'b0) begin
      errors++; $display("FAIL top_exit: active=%b on=%b expected 0 0", bullet_active, bullet_on);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, (i % 2 == 0) && (i < 8), 1'b0);
      checks++; if (shot_fired !== 1'b0 || bullet_active !== 1'b0) begin
        errors++; $display("FAIL cooldown_tick%0d: shot=%b active=%b expected 0 0", i, shot_fired, bullet_active);
      end
    end
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if (shot_fired !== 1'b1) begin errors++; $display("FAIL fire_after_cooldown: shot=%b expected 1", shot_fired); end
  endtask

  task automatic test_hit;
    do_reset(1'b0);
    ship_x_pos = 10'd312; scale = 4'd1;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    pix_x = 10'd318; pix_y = 10'd428; #1;
    checks++; if (bullet_active !== 1'b0 || bullet_y !== 10'd428 || bullet_on !== 1'b0) begin
      errors++; $display("FAIL hit_with_tick: active=%b y=%0d on=%b expected 0 428 0", bullet_active, bullet_y, bullet_on);
    end
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (bullet_active !== 1'b0 || shot_fired !== 1'b0 || bullet_y !== 10'd428) begin
      errors++; $display("FAIL hit_in_idle: active=%b shot=%b y=%0d expected 0 0 428", bullet_active, shot_fired, bullet_y);
    end
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if (shot_fired !== 1'b1) begin errors++; $display("FAIL refire_after_hit: shot=%b expected 1", shot_fired); end
  endtask

  task automatic test_clamp;
    logic [9:0] xs [4];
    logic [3:0] ss [4];
    logic [9:0] ex [4];
    xs = '{10'd630, 10'd0, 10'd626, 10'd625};
    ss = '{4'd2, 4'd4, 4'd2, 4'd2};
    ex = '{10'd638, 10'd24, 10'd638, 10'd637};
    for (int i = 0; i < 4; i++) begin
      do_reset(1'b0);
      ship_x_pos = xs[i]; scale = ss[i];
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      checks++; if (bullet_x !== ex[i]) begin
        errors++; $display("FAIL clamp_%0d: x=%0d expected %0d", i, bullet_x, ex[i]);
      end
    end
  endtask

  task automatic test_async_reset;
    do_reset(1'b0);
    ship_x_pos = 10'd312; scale = 4'd1;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    pix_x = 10'd318; pix_y = 10'd434;
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    checks++; if (bullet_active !== 1'b0 || bullet_on !== 1'b0 || bullet_x !== 10'd0 || bullet_y !== 10'd0 || shot_fired !== 1'b0) begin
      errors++; $display("FAIL async_reset: active=%b on=%b x=%0d y=%0d shot=%b expected all 0", bullet_active, bullet_on, bullet_x, bullet_y, shot_fired);
    end
    @(negedge clk); rst_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if (shot_fired !== 1'b0) begin errors++; $display("FAIL held_after_reset: shot=%b expected 0", shot_fired); end
  endtask

  task automatic test_random;
    bit f;
    int px, py;
    do_reset(1'b0);
    f = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) f = ~f;
      if ($urandom_range(0, 9) == 0) begin
        ship_x_pos = 10'($urandom_range(0, 639));
        scale = 4'($urandom_range(0, 15));
      end
      cyc($urandom_range(0, 4) == 0, f, $urandom_range(0, 59) == 0);
      px = m_x + $urandom_range(0, 3) - 1;
      py = m_y + $urandom_range(0, 7) - 1;
      if ($urandom_range(0, 3) == 0) begin px = $urandom_range(0, 639); py = $urandom_range(0, 479); end
      if (px < 0) px = 0;
      if (py < 0) py = 0;
      pix_x = 10'(px); pix_y = 10'(py); #1;
      checks++; if (bullet_active !== m_fly || shot_fired !== m_shot || bullet_x !== 10'(m_x) || bullet_y !== 10'(m_y)) begin
        errors++; $display("FAIL rand_state@%0d: active=%b shot=%b x=%0d y=%0d expected %b %b %0d %0d", i, bullet_active, shot_fired, bullet_x, bullet_y, m_fly, m_shot, m_x, m_y);
      end
      checks++; if (bullet_on !== (m_fly && px >= m_x && px < m_x + 2 && py >= m_y && py < m_y + 6)) begin
        errors++; $display("FAIL rand_on@%0d: got %b at (%0d,%0d) bullet (%0d,%0d) fly=%b", i, bullet_on, px, py, m_x, m_y, m_fly);
      end
    end
  endtask

  initial begin
    test_reset;
    test_spawn;
    test_top_exit;
    test_hit;
    test_clamp;
    test_async_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
